io_port_responder: RTL and testbench

- Memory-mapped I/O responder on the far end of the CPU's transceiver data path.
- CPU side: the CPU initiates single reads and writes with a req/ack handshake.
- External side: two latched output ports and an input capture FIFO fed by a strobe.
- Gives the CPU a polled (or optionally interrupt-driven) path to external devices.

---
 rtl/io_port_responder.sv | 161 ++++++++++++++++
 tb/tb_io_port_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// io_port_responder
//   Memory-mapped I/O responder for the CPU transceiver data path.
//   The CPU performs single reads and writes with a level req / pulsed ack
//   handshake. The external side has two latched output ports and a small
//   capture FIFO that is filled by a one-cycle strobe.
//
//   Register map (cpu_addr):
//     0 OUT0   r/w
//     1 OUT1   r/w
//     2 FIFO   read pops the head (0 when empty); writes are acked and ignored
//     3 STATUS {irq_en, ovf, full, not_empty}; write bit2=1 clears ovf,
//              bit3 loads irq_en
//
//   Ports:
//     clk, reset (async, active low)
//     cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ack
//     ext_out0, ext_out1                   registered output ports
//     ext_in_stb, ext_in_data              FIFO capture strobe and data
//     irq                                  only when IO_IRQ_EN is defined
//
//   Optional feature macro: IO_IRQ_EN (adds irq port and irq_en bit).
module io_port_responder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] ext_out0,
    output logic [DATA_W-1:0] ext_out1,
    input  logic              ext_in_stb,
    input  logic [DATA_W-1:0] ext_in_data
`ifdef IO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              ovf;
    logic              empty, full;
    logic              accept, pop, push, ovf_set, ovf_clr;
    logic [DATA_W-1:0] status, rd_val;

`ifdef IO_IRQ_EN
    logic irq_en;
`endif

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cpu_ack   = 1'b0;
        case (state)
            IDLE:     if (cpu_req) state_nxt = ACK;
            ACK: begin
                cpu_ack   = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: if (!cpu_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The access itself happens on the edge that leaves IDLE.
    assign accept = (state == IDLE) && cpu_req;

    // ---------------- FIFO flags and control ----------------
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign pop     = accept && !cpu_we && (cpu_addr == 2'd2) && !empty;
    // A same-edge pop frees a slot, so full is judged after the pop.
    assign push    = ext_in_stb && (!full || pop);
    assign ovf_set = ext_in_stb && full && !pop;
    assign ovf_clr = accept && cpu_we && (cpu_addr == 2'd3) && cpu_wdata[2];

    always_comb begin
        status    = '0;
        status[0] = !empty;
        status[1] = full;
        status[2] = ovf;
`ifdef IO_IRQ_EN
        status[3] = irq_en;
`endif
    end

    always_comb begin
        rd_val = '0;
        case (cpu_addr)
            2'd0: rd_val = ext_out0;
            2'd1: rd_val = ext_out1;
            2'd2: rd_val = empty ? '0 : mem[rd_ptr[AW-1:0]];
            2'd3: rd_val = status;
            default: rd_val = '0;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata <= '0;
            ext_out0  <= '0;
            ext_out1  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept && !cpu_we) cpu_rdata <= rd_val;
            if (accept && cpu_we) begin
                case (cpu_addr)
                    2'd0:    ext_out0 <= cpu_wdata;
                    2'd1:    ext_out1 <= cpu_wdata;
                    default: ;
                endcase
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= ext_in_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            // A drop on the clearing edge still leaves ovf set.
            if (ovf_clr) ovf <= 1'b0;
            if (ovf_set) ovf <= 1'b1;
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (accept && cpu_we && (cpu_addr == 2'd3)) irq_en <= cpu_wdata[3];
            irq <= irq_en && (!empty || ovf);
        end
    end
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder
//   Table-driven vectors, hand sequences for FIFO corner cases, and random
//   accesses checked against a queue-based reference model.
module tb_io_port_responder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [1:0]        cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] ext_out0, ext_out1;
    logic              ext_in_stb;
    logic [DATA_W-1:0] ext_in_data;
`ifdef IO_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    io_port_responder #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ext_out0(ext_out0), .ext_out1(ext_out1),
        .ext_in_stb(ext_in_stb), .ext_in_data(ext_in_data)
`ifdef IO_IRQ_EN
        , .irq(irq)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0] m_q[$];
    bit [7:0] m_out0, m_out1;
    bit       m_ovf, m_irq_en;

    task automatic model_reset();
        m_q.delete();
        m_out0 = 0; m_out1 = 0; m_ovf = 0; m_irq_en = 0;
    endtask

    function automatic bit [7:0] m_status();
        bit [7:0] s;
        s = 0;
        s[0] = (m_q.size() != 0);
        s[1] = (m_q.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_irq_en;
        return s;
    endfunction

    task automatic model_access(input bit we, input bit [1:0] addr, input bit [7:0] wd,
                                input bit stb, input bit [7:0] sd, output bit [7:0] rd);
        rd = 0;
        case (addr)
            2'd0: rd = m_out0;
            2'd1: rd = m_out1;
            2'd2: rd = (m_q.size() != 0) ? m_q[0] : 8'h00;
            2'd3: rd = m_status();
        endcase
        if (!we && addr == 2'd2 && m_q.size() != 0) void'(m_q.pop_front());
        if (we) begin
            case (addr)
                2'd0: m_out0 = wd;
                2'd1: m_out1 = wd;
                2'd3: begin
                    if (wd[2]) m_ovf = 0;
`ifdef IO_IRQ_EN
                    m_irq_en = wd[3];
`endif
                end
                default: ;
            endcase
        end
        if (stb) begin
            if (m_q.size() < DEPTH) m_q.push_back(sd);
            else m_ovf = 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_access(input bit we, input bit [1:0] addr, input bit [7:0] wd,
                             input bit stb, input bit [7:0] sd, output bit [7:0] rd);
        bit [7:0] exp_rd;
        @(negedge clk);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        ext_in_stb = stb; ext_in_data = sd;
        model_access(we, addr, wd, stb, sd, exp_rd);
        @(negedge clk);
        ext_in_stb = 0;
        cpu_req = 0;
        check("ack_latency", cpu_ack, 1);
        rd = cpu_rdata;
        if (!we) check("rdata_model", cpu_rdata, exp_rd);
        check("ext_out0", ext_out0, m_out0);
        check("ext_out1", ext_out1, m_out1);
        @(negedge clk);
        check("ack_width", cpu_ack, 0);
    endtask

    task automatic strobe(input bit [7:0] d);
        @(negedge clk);
        ext_in_stb = 1; ext_in_data = d;
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1;
        @(negedge clk);
        ext_in_stb = 0;
    endtask

    typedef struct {
        bit       we;
        bit [1:0] addr;
        bit [7:0] wd;
        bit       stb;
        bit [7:0] sd;
        bit [7:0] exp_rd;
        bit [7:0] exp_out0;
        bit [7:0] exp_out1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit [7:0] rd;
        int       acks;

        tbl[0]  = '{1, 2'd0, 8'hA5, 0, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[1]  = '{0, 2'd0, 8'h00, 0, 8'h00, 8'hA5, 8'hA5, 8'h00};
        tbl[2]  = '{1, 2'd1, 8'h3C, 0, 8'h00, 8'h00, 8'hA5, 8'h3C};
        tbl[3]  = '{0, 2'd1, 8'h00, 0, 8'h00, 8'h3C, 8'hA5, 8'h3C};
        tbl[4]  = '{0, 2'd3, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 8'h3C};
        tbl[5]  = '{0, 2'd2, 8'h00, 1, 8'h77, 8'h00, 8'hA5, 8'h3C};
        tbl[6]  = '{0, 2'd3, 8'h00, 0, 8'h00, 8'h01, 8'hA5, 8'h3C};
        tbl[7]  = '{0, 2'd2, 8'h00, 0, 8'h00, 8'h77, 8'hA5, 8'h3C};
        tbl[8]  = '{0, 2'd2, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 8'h3C};
        tbl[9]  = '{1, 2'd2, 8'hFF, 0, 8'h00, 8'h00, 8'hA5, 8'h3C};
        tbl[10] = '{0, 2'd3, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 8'h3C};

        reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_in_stb = 0; ext_in_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_ack", cpu_ack, 0);
        check("reset_rdata", cpu_rdata, 0);
        check("reset_out0", ext_out0, 0);
        check("reset_out1", ext_out1, 0);
        reset = 1;

        // Reset asserted during the ACK cycle.
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 0; cpu_wdata = 8'h5A;
        @(negedge clk);
        check("pre_reset_ack", cpu_ack, 1);
        check("pre_reset_out0", ext_out0, 8'h5A);
        reset = 0;
        #1;
        check("midack_reset_ack", cpu_ack, 0);
        check("midack_reset_out0", ext_out0, 0);
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        do_access(0, 2'd3, 0, 0, 0, rd);
        check("status_after_reset", rd, 8'h00);

        // Table vectors.
        foreach (tbl[i]) begin
            do_access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].stb, tbl[i].sd, rd);
            if (!tbl[i].we) check("tbl_rdata", rd, tbl[i].exp_rd);
            check("tbl_out0", ext_out0, tbl[i].exp_out0);
            check("tbl_out1", ext_out1, tbl[i].exp_out1);
        end

        // Held request gives exactly one ack.
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 2'd0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        check("held_req_acks", acks, 1);
        check("held_req_rdata", cpu_rdata, 8'hA5);
        cpu_req = 0;
        @(negedge clk);

        // Fill, overflow, drain.
        strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
        do_access(0, 2'd3, 0, 0, 0, rd);
        check("status_full", rd, 8'h03);
        strobe(8'h55);
        do_access(0, 2'd3, 0, 0, 0, rd);
        check("status_ovf", rd, 8'h07);
        do_access(0, 2'd2, 0, 0, 0, rd); check("pop0", rd, 8'h11);
        do_access(0, 2'd2, 0, 0, 0, rd); check("pop1", rd, 8'h22);
        do_access(0, 2'd2, 0, 0, 0, rd); check("pop2", rd, 8'h33);
        do_access(0, 2'd2, 0, 0, 0, rd); check("pop3", rd, 8'h44);
        do_access(0, 2'd2, 0, 0, 0, rd); check("pop_empty", rd, 8'h00);
        do_access(0, 2'd3, 0, 0, 0, rd); check("status_empty_ovf", rd, 8'h04);
        do_access(1, 2'd3, 8'h04, 0, 0, rd);
        do_access(0, 2'd3, 0, 0, 0, rd); check("status_ovf_cleared", rd, 8'h00);

        // Full FIFO: pop coincident with a strobe is accepted without ovf.
        strobe(8'hA1); strobe(8'hA2); strobe(8'hA3); strobe(8'hA4);
        do_access(0, 2'd2, 0, 1, 8'h66, rd); check("full_pop_push", rd, 8'hA1);
        do_access(0, 2'd3, 0, 0, 0, rd); check("full_no_ovf", rd, 8'h03);
        do_access(0, 2'd2, 0, 0, 0, rd); check("fpp1", rd, 8'hA2);
        do_access(0, 2'd2, 0, 0, 0, rd); check("fpp2", rd, 8'hA3);
        do_access(0, 2'd2, 0, 0, 0, rd); check("fpp3", rd, 8'hA4);
        do_access(0, 2'd2, 0, 0, 0, rd); check("fpp4", rd, 8'h66);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                strobe(8'($urandom));
            end else begin
                do_access(1'($urandom), 2'($urandom), 8'($urandom),
                          ($urandom_range(0, 2) == 0), 8'($urandom), rd);
            end
        end

`ifdef IO_IRQ_EN
        while (m_q.size() != 0) do_access(0, 2'd2, 0, 0, 0, rd);
        do_access(1, 2'd3, 8'h04, 0, 0, rd);
        do_access(1, 2'd3, 8'h08, 0, 0, rd);
        check("irq_idle", irq, 0);
        @(negedge clk);
        ext_in_stb = 1; ext_in_data = 8'h01;
        m_q.push_back(8'h01);
        @(negedge clk);
        ext_in_stb = 0;
        @(negedge clk);
        check("irq_set", irq, 1);
        do_access(0, 2'd2, 0, 0, 0, rd);
        check("irq_pop_data", rd, 8'h01);
        check("irq_clear", irq, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
